// File: rtl/chip8_timer_ctrl.sv
// CHIP-8 delay/sound timer scheduler: 60 Hz prescaler, shared saturating decrementer, CPU write port.
// Optional square-wave buzzer tone generator enabled by defining CHIP8_TIMER_TONE_EN.
module chip8_timer_ctrl #(
    parameter int CLK_HZ  = 27000000,
    parameter int TICK_HZ = 60,
    parameter int TONE_HZ = 440
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       wr_sel,
    input  logic [7:0] wr_data,
    output logic [7:0] delay_val,
    output logic [7:0] sound_val,
    output logic       sound_on,
    output logic       buzzer,
    output logic       tick,
    output logic       overrun
);

    localparam int DATA_W = 8;
    localparam int DIV    = CLK_HZ / TICK_HZ;
    localparam int PW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PCNT_MAX = PW'(DIV - 1);

    if (DIV < 1 || TONE_HZ < 1) begin : g_cfg_err
        $error("chip8_timer_ctrl: CLK_HZ/TICK_HZ and TONE_HZ must be positive");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DEC_DT = 2'd1,
        DEC_ST = 2'd2
    } state_t;

    function automatic logic [DATA_W-1:0] sat_dec(input logic [DATA_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    logic [PW-1:0]     pcnt_q, pcnt_d;
    logic              tick_q, tick_d;
    state_t            state_q, state_d;
    logic [DATA_W-1:0] delay_q, delay_d;
    logic [DATA_W-1:0] sound_q, sound_d;
    logic              pend_q, pend_d;
    logic              overrun_q, overrun_d;

    always_comb begin
        pcnt_d = pcnt_q;
        tick_d = 1'b0;
        if (en) begin
            if (pcnt_q == PCNT_MAX) begin
                pcnt_d = '0;
                tick_d = 1'b1;
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end
        end
    end

    // A write landing in IDLE on the same edge as the sequence start is decremented by that sequence.
    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        sound_d   = sound_q;
        pend_d    = pend_q;
        overrun_d = overrun_q;
        case (state_q)
            IDLE: begin
                if (wr_valid) begin
                    if (wr_sel) begin
                        sound_d = wr_data;
                    end else begin
                        delay_d = wr_data;
                    end
                end
                if (tick_q || pend_q) begin
                    state_d = DEC_DT;
                    pend_d  = 1'b0;
                end
            end
            DEC_DT: begin
                delay_d = sat_dec(delay_q);
                state_d = DEC_ST;
            end
            DEC_ST: begin
                sound_d = sat_dec(sound_q);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (tick_q && (state_q != IDLE)) begin
            if (pend_q) begin
                overrun_d = 1'b1;
            end else begin
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q    <= '0;
            tick_q    <= 1'b0;
            state_q   <= IDLE;
            delay_q   <= '0;
            sound_q   <= '0;
            pend_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            pcnt_q    <= pcnt_d;
            tick_q    <= tick_d;
            state_q   <= state_d;
            delay_q   <= delay_d;
            sound_q   <= sound_d;
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
        end
    end

    assign wr_ready  = (state_q == IDLE);
    assign delay_val = delay_q;
    assign sound_val = sound_q;
    assign sound_on  = |sound_q;
    assign tick      = tick_q;
    assign overrun   = overrun_q;

`ifdef CHIP8_TIMER_TONE_EN
    localparam int HALF = CLK_HZ / (2 * TONE_HZ);
    localparam int TW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [TW-1:0] TONE_MAX = TW'(HALF - 1);

    logic [TW-1:0] tone_cnt_q, tone_cnt_d;
    logic          buzz_q, buzz_d;

    always_comb begin
        tone_cnt_d = '0;
        buzz_d     = 1'b0;
        if (sound_on) begin
            if (tone_cnt_q == TONE_MAX) begin
                tone_cnt_d = '0;
                buzz_d     = ~buzz_q;
            end else begin
                tone_cnt_d = tone_cnt_q + 1'b1;
                buzz_d     = buzz_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tone_cnt_q <= '0;
            buzz_q     <= 1'b0;
        end else begin
            tone_cnt_q <= tone_cnt_d;
            buzz_q     <= buzz_d;
        end
    end

    // Gate with sound_on so the output drops the same cycle ST reaches zero.
    assign buzzer = buzz_q & sound_on;
`else
    assign buzzer = sound_on;
`endif

endmodule

// File: tb/tb_chip8_timer_ctrl.sv
// Scoreboard bench for chip8_timer_ctrl: event-scheduled reference model feeds an expectation queue.
module tb_chip8_timer_ctrl;

    localparam int CLK_HZ  = 240;
    localparam int TICK_HZ = 60;
    localparam int TONE_HZ = 30;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int HALF    = CLK_HZ / (2 * TONE_HZ);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_sel = 1'b0;
    logic [7:0] wr_data = 8'd0;
    logic       wr_ready, sound_on, buzzer, tick, overrun;
    logic [7:0] delay_val, sound_val;

    logic       en2 = 1'b1;
    logic       wv2 = 1'b0;
    logic       sel2 = 1'b0;
    logic [7:0] wd2 = 8'd0;
    logic       u2_ready, u2_sound_on, u2_buzzer, u2_tick, u2_overrun;
    logic [7:0] u2_delay, u2_sound;

    chip8_timer_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .TONE_HZ(TONE_HZ)) dut (
        .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_sel(wr_sel), .wr_data(wr_data), .delay_val(delay_val), .sound_val(sound_val),
        .sound_on(sound_on), .buzzer(buzzer), .tick(tick), .overrun(overrun)
    );

    // Tick every cycle so ticks pile up behind a running sequence.
    chip8_timer_ctrl #(.CLK_HZ(TICK_HZ), .TICK_HZ(TICK_HZ), .TONE_HZ(TONE_HZ)) dut_ovr (
        .clk(clk), .rst(rst), .en(en2), .wr_valid(wv2), .wr_ready(u2_ready),
        .wr_sel(sel2), .wr_data(wd2), .delay_val(u2_delay), .sound_val(u2_sound),
        .sound_on(u2_sound_on), .buzzer(u2_buzzer), .tick(u2_tick), .overrun(u2_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int dt;
        int st;
        int tk;
        int rdy;
        int buz;
        int ovr2;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state: timer values plus the cycle on which the last tick was visible.
    int cyc      = 0;
    int seq      = -100;
    int en_cnt   = 0;
    int m_dt     = 0;
    int m_st     = 0;
    int tone_run = 0;
    int en2_cnt  = 0;
    int m_ovr2   = 0;
    int last_tk  = 0;

    task automatic chk(input string nm, input int c, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, c, act, expv);
        end
    endtask

    function automatic bit busy(input int c);
        return (c == seq + 1) || (c == seq + 2);
    endfunction

    // Apply one cycle of stimulus, advance the model across the edge, queue the expectation.
    task automatic step(input bit r, input bit e, input bit wv, input bit s, input int d,
                        output bit acc);
        exp_t x;
        int   st_before;
        rst = r; en = e; wr_valid = wv; wr_sel = s; wr_data = 8'(d);
        @(posedge clk);
        cyc++;
        acc = 1'b0;
        last_tk = 0;
        if (r) begin
            seq = -100; en_cnt = 0; m_dt = 0; m_st = 0;
            tone_run = 0; en2_cnt = 0; m_ovr2 = 0;
        end else begin
            st_before = m_st;
            if (wv && !busy(cyc - 1)) begin
                acc = 1'b1;
                if (s) m_st = d; else m_dt = d;
            end
            if (cyc == seq + 2 && m_dt > 0) m_dt = m_dt - 1;
            if (cyc == seq + 3 && m_st > 0) m_st = m_st - 1;
            if (e) begin
                if (en_cnt % DIV == DIV - 1) begin
                    last_tk = 1;
                    seq = cyc;
                end
                en_cnt++;
            end
            tone_run = (st_before != 0) ? tone_run + 1 : 0;
            en2_cnt++;
            if (en2_cnt >= 4) m_ovr2 = 1;
        end
        x.cyc  = cyc;
        x.dt   = m_dt;
        x.st   = m_st;
        x.tk   = last_tk;
        x.rdy  = busy(cyc) ? 0 : 1;
`ifdef CHIP8_TIMER_TONE_EN
        x.buz  = (m_st != 0 && ((tone_run / HALF) % 2) == 1) ? 1 : 0;
`else
        x.buz  = (m_st != 0) ? 1 : 0;
`endif
        x.ovr2 = m_ovr2;
        exp_q.push_back(x);
        #1;
    endtask

    task automatic idle(input int n, input bit e);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, e, 1'b0, 1'b0, 0, a);
    endtask

    task automatic write(input bit s, input int d);
        bit a;
        int tries;
        a = 1'b0;
        tries = 0;
        while (!a && tries < 20) begin
            step(1'b0, 1'b1, 1'b1, s, d, a);
            tries++;
        end
        if (!a) chk("write_accept_timeout", cyc, 0, 1);
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        idle(1, 1'b1);
        while (last_tk == 0 && n < 20) begin
            idle(1, 1'b1);
            n++;
        end
        if (last_tk == 0) chk("tick_timeout", cyc, 0, 1);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("delay_val", x.cyc, int'(delay_val), x.dt);
                chk("sound_val", x.cyc, int'(sound_val), x.st);
                chk("sound_on", x.cyc, int'(sound_on), (x.st != 0) ? 1 : 0);
                chk("tick", x.cyc, int'(tick), x.tk);
                chk("wr_ready", x.cyc, int'(wr_ready), x.rdy);
                chk("overrun", x.cyc, int'(overrun), 0);
                chk("buzzer", x.cyc, int'(buzzer), x.buz);
                chk("overrun_stress", x.cyc, int'(u2_overrun), x.ovr2);
            end
        end
    end

    initial begin : driver
        bit a;
        bit pending;
        bit p_sel;
        int p_dat;
        int n;
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, a);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, a);
        idle(3, 1'b0);
        idle(13, 1'b1);
        write(1'b0, 8);
        idle(45, 1'b1);
        write(1'b1, 2);
        idle(12, 1'b1);
        wait_tick();
        idle(1, 1'b1);
        write(1'b0, 77);
        idle(6, 1'b1);
        wait_tick();
        write(1'b0, 5);
        idle(6, 1'b1);
        write(1'b1, 1);
        idle(10, 1'b1);
        write(1'b1, 9);
        idle(20, 1'b0);
        idle(30, 1'b1);
        pending = 1'b0; p_sel = 1'b0; p_dat = 0;
        for (int i = 0; i < 700; i++) begin
            if (i == 350) begin
                step(1'b1, 1'b1, 1'b0, 1'b0, 0, a);
                step(1'b1, 1'b1, 1'b0, 1'b0, 0, a);
                pending = 1'b0;
            end
            if (!pending && $urandom_range(0, 9) < 2) begin
                pending = 1'b1;
                p_sel = 1'($urandom_range(0, 1));
                p_dat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(0, 255);
            end
            step(1'b0, ($urandom_range(0, 9) < 8), pending, p_sel, p_dat, a);
            if (a) pending = 1'b0;
        end
        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        #2;
        if (exp_q.size() != 0) chk("scoreboard_drain", cyc, exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
